weight_bias_streamer: RTL and testbench

- Upstream feeder for the PE_LP array in MAC mode.
- Reads the Weight RAM and Bias RAM and streams, per output channel, Taps weight beats followed by exactly one bias beat.
- Drives Weight_valid_in/Weight_in and Bias_valid_in/Bias_in of the PEs. The PE store address advances on each bias beat.
- Honours the controller En_in hold and the layer_done_in abort.

---
 rtl/weight_bias_streamer_pkg.sv | 16 +
 rtl/wbs_skid_reg.sv | 57 +++++
 rtl/weight_bias_streamer.sv | 167 ++++++++++++++++
 tb/tb_weight_bias_streamer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/weight_bias_streamer_pkg.sv
// Shared definitions for the weight/bias streamer.
//   WORD_BITS   : width of one weight or bias word (RAM data and PE beats).
//   wbs_state_e : streamer FSM state encoding (3 bits).
package weight_bias_streamer_pkg;

  localparam int WORD_BITS = 16;

  typedef enum logic [2:0] {
    WBS_IDLE   = 3'd0,
    WBS_WEIGHT = 3'd1,
    WBS_BIAS   = 3'd2,
    WBS_DRAIN  = 3'd3,
    WBS_DONE   = 3'd4
  } wbs_state_e;

endpackage

// File: rtl/wbs_skid_reg.sv
// One-entry holding register for a beat returning from RAM while the consumer
// stalls. When empty, the incoming beat passes straight through; when full,
// the held beat is presented until an edge with en_i=1 consumes it.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (drops any held beat)
//   en_i          : consumer accept for the presented beat
//   in_valid_i    : a RAM word is arriving this cycle
//   in_bias_i     : arriving word is a bias (1) or a weight (0)
//   in_data_i     : arriving word
//   out_valid_o   : a beat is presented
//   out_bias_o    : presented beat type
//   out_data_o    : presented beat data
module wbs_skid_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  input  logic             in_bias_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic             out_bias_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic             full_q;
  logic             bias_q;
  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the data word is reset along with the flag; it is a single register,
  // not a memory array, so resetting it is cheap and keeps outputs defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      bias_q <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (full_q) begin
      if (en_i) full_q <= 1'b0;
    end else if (in_valid_i && !en_i) begin
      full_q <= 1'b1;
      bias_q <= in_bias_i;
      data_q <= in_data_i;
    end
  end

  assign out_valid_o = full_q || in_valid_i;
  assign out_bias_o  = full_q ? bias_q : in_bias_i;
  assign out_data_o  = full_q ? data_q : in_data_i;

endmodule

// File: rtl/weight_bias_streamer.sv
// Feeds the PE array in MAC mode: for each output channel, streams Taps weight
// beats from the Weight RAM followed by one bias beat from the Bias RAM.
// Ports:
//   CLK, RST                  : clock, asynchronous active-low reset
//   Start_in                  : start pulse, accepted only in IDLE
//   layer_done_in             : synchronous abort back to IDLE (no Done)
//   En_in                     : downstream accept of the presented beat
//   Taps_in/Num_OC_in         : weights per channel / channel count
//   W_base_in/B_base_in       : first weight / bias RAM address
//   W_RAM_*/B_RAM_*           : RAM read ports (data valid 1 cycle after en)
//   Weight_valid_out/Weight_out, Bias_valid_out/Bias_out : PE beats
//   Busy_out, Done_out        : stream in progress / completion pulse
module weight_bias_streamer
  import weight_bias_streamer_pkg::*;
#(
  parameter int W_ADDR_BITS = 10,
  parameter int B_ADDR_BITS = 6,
  parameter int TAP_BITS    = 8,
  parameter int OC_BITS     = 6
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Start_in,
  input  logic                        layer_done_in,
  input  logic                        En_in,
  input  logic [TAP_BITS-1:0]         Taps_in,
  input  logic [OC_BITS-1:0]          Num_OC_in,
  input  logic [W_ADDR_BITS-1:0]      W_base_in,
  input  logic [B_ADDR_BITS-1:0]      B_base_in,
  output logic                        W_RAM_en_out,
  output logic [W_ADDR_BITS-1:0]      W_RAM_addr_out,
  input  logic [WORD_BITS-1:0]        W_RAM_dout_in,
  output logic                        B_RAM_en_out,
  output logic [B_ADDR_BITS-1:0]      B_RAM_addr_out,
  input  logic [WORD_BITS-1:0]        B_RAM_dout_in,
  output logic                        Weight_valid_out,
  output logic signed [WORD_BITS-1:0] Weight_out,
  output logic                        Bias_valid_out,
  output logic signed [WORD_BITS-1:0] Bias_out,
  output logic                        Busy_out,
  output logic                        Done_out
);

  wbs_state_e             state_q;
  logic [TAP_BITS-1:0]    taps_q, tap_q;
  logic [OC_BITS-1:0]     num_oc_q, oc_q;
  logic [W_ADDR_BITS-1:0] w_addr_q;
  logic [B_ADDR_BITS-1:0] b_base_q;
  logic                   pend_q, pend_bias_q;
  logic                   busy_q, done_q;

  logic                   w_issue, b_issue, last_tap, last_oc;
  logic                   beat_valid, beat_bias;
  logic [WORD_BITS-1:0]   beat_data, ram_data;

  // A held beat drains on any edge with En_in=1, so En_in alone guarantees a
  // free slot for the word a read issued this cycle will return.
  assign w_issue  = (state_q == WBS_WEIGHT) && En_in && !layer_done_in;
  assign b_issue  = (state_q == WBS_BIAS) && En_in && !layer_done_in;
  assign last_tap = (tap_q == taps_q - TAP_BITS'(1));
  assign last_oc  = (oc_q == num_oc_q - OC_BITS'(1));
  assign ram_data = pend_bias_q ? B_RAM_dout_in : W_RAM_dout_in;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= WBS_IDLE;
      taps_q      <= '0;
      tap_q       <= '0;
      num_oc_q    <= '0;
      oc_q        <= '0;
      w_addr_q    <= '0;
      b_base_q    <= '0;
      pend_q      <= 1'b0;
      pend_bias_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (layer_done_in) begin
      state_q     <= WBS_IDLE;
      tap_q       <= '0;
      oc_q        <= '0;
      w_addr_q    <= '0;
      pend_q      <= 1'b0;
      pend_bias_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // pend_q marks that the RAM presents a word this coming cycle.
      pend_q      <= w_issue || b_issue;
      pend_bias_q <= b_issue;
      done_q      <= 1'b0;
      case (state_q)
        WBS_IDLE: begin
          if (Start_in) begin
            taps_q   <= Taps_in;
            num_oc_q <= Num_OC_in;
            w_addr_q <= W_base_in;
            b_base_q <= B_base_in;
            tap_q    <= '0;
            oc_q     <= '0;
            busy_q   <= 1'b1;
            if (Num_OC_in == '0)    state_q <= WBS_DONE;
            else if (Taps_in == '0) state_q <= WBS_BIAS;
            else                    state_q <= WBS_WEIGHT;
          end
        end
        WBS_WEIGHT: begin
          if (w_issue) begin
            // The weight address runs on across channels and wraps freely.
            w_addr_q <= w_addr_q + W_ADDR_BITS'(1);
            if (last_tap) begin
              tap_q   <= '0;
              state_q <= WBS_BIAS;
            end else begin
              tap_q <= tap_q + TAP_BITS'(1);
            end
          end
        end
        WBS_BIAS: begin
          if (b_issue) begin
            if (last_oc) begin
              state_q <= WBS_DRAIN;
            end else begin
              oc_q    <= oc_q + OC_BITS'(1);
              state_q <= (taps_q == '0) ? WBS_BIAS : WBS_WEIGHT;
            end
          end
        end
        WBS_DRAIN: begin
          if (!beat_valid || En_in) state_q <= WBS_DONE;
        end
        WBS_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= WBS_IDLE;
        end
        default: state_q <= WBS_IDLE;
      endcase
    end
  end

  wbs_skid_reg #(
    .WIDTH(WORD_BITS)
  ) u_skid (
    .clk        (CLK),
    .rst_n      (RST),
    .clr_i      (layer_done_in),
    .en_i       (En_in),
    .in_valid_i (pend_q),
    .in_bias_i  (pend_bias_q),
    .in_data_i  (ram_data),
    .out_valid_o(beat_valid),
    .out_bias_o (beat_bias),
    .out_data_o (beat_data)
  );

  assign W_RAM_en_out     = w_issue;
  assign W_RAM_addr_out   = w_addr_q;
  assign B_RAM_en_out     = b_issue;
  assign B_RAM_addr_out   = b_base_q + B_ADDR_BITS'(oc_q);
  assign Weight_valid_out = beat_valid && !beat_bias;
  assign Bias_valid_out   = beat_valid && beat_bias;
  assign Weight_out       = Weight_valid_out ? beat_data : '0;
  assign Bias_out         = Bias_valid_out ? beat_data : '0;
  assign Busy_out         = busy_q;
  assign Done_out         = done_q;

endmodule

// File: tb/tb_weight_bias_streamer.sv
module tb_weight_bias_streamer;
  import weight_bias_streamer_pkg::*;

  localparam int W_ADDR_BITS = 10;
  localparam int B_ADDR_BITS = 6;
  localparam int TAP_BITS    = 8;
  localparam int OC_BITS     = 6;

  logic                        CLK = 1'b0;
  logic                        RST = 1'b0;
  logic                        Start_in = 1'b0;
  logic                        layer_done_in = 1'b0;
  logic                        En_in = 1'b0;
  logic [TAP_BITS-1:0]         Taps_in = '0;
  logic [OC_BITS-1:0]          Num_OC_in = '0;
  logic [W_ADDR_BITS-1:0]      W_base_in = '0;
  logic [B_ADDR_BITS-1:0]      B_base_in = '0;
  logic                        W_RAM_en_out, B_RAM_en_out;
  logic [W_ADDR_BITS-1:0]      W_RAM_addr_out;
  logic [B_ADDR_BITS-1:0]      B_RAM_addr_out;
  logic [WORD_BITS-1:0]        W_RAM_dout_in = '0;
  logic [WORD_BITS-1:0]        B_RAM_dout_in = '0;
  logic                        Weight_valid_out, Bias_valid_out;
  logic signed [WORD_BITS-1:0] Weight_out, Bias_out;
  logic                        Busy_out, Done_out;

  weight_bias_streamer #(
    .W_ADDR_BITS(W_ADDR_BITS), .B_ADDR_BITS(B_ADDR_BITS),
    .TAP_BITS(TAP_BITS), .OC_BITS(OC_BITS)
  ) dut (
    .CLK(CLK), .RST(RST), .Start_in(Start_in), .layer_done_in(layer_done_in),
    .En_in(En_in), .Taps_in(Taps_in), .Num_OC_in(Num_OC_in),
    .W_base_in(W_base_in), .B_base_in(B_base_in),
    .W_RAM_en_out(W_RAM_en_out), .W_RAM_addr_out(W_RAM_addr_out), .W_RAM_dout_in(W_RAM_dout_in),
    .B_RAM_en_out(B_RAM_en_out), .B_RAM_addr_out(B_RAM_addr_out), .B_RAM_dout_in(B_RAM_dout_in),
    .Weight_valid_out(Weight_valid_out), .Weight_out(Weight_out),
    .Bias_valid_out(Bias_valid_out), .Bias_out(Bias_out),
    .Busy_out(Busy_out), .Done_out(Done_out)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read RAM models.
  logic [WORD_BITS-1:0] wmem [0:(1<<W_ADDR_BITS)-1];
  logic [WORD_BITS-1:0] bmem [0:(1<<B_ADDR_BITS)-1];
  always @(posedge CLK) begin
    if (W_RAM_en_out) W_RAM_dout_in <= wmem[W_RAM_addr_out];
    if (B_RAM_en_out) B_RAM_dout_in <= bmem[B_RAM_addr_out];
  end

  typedef struct packed {
    logic                 bias;
    logic [WORD_BITS-1:0] data;
    int                   cyc;
  } beat_t;

  typedef struct {
    int taps, noc, wb, bb;
    int stall_at, stall_len, restart_at;
    int exp_beats, exp_first, exp_last, exp_done, exp_busy;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor state; written only by the monitor process.
  beat_t beats[$];
  int ncnt = 0, done_tot = 0, done_last = 0, busy_tot = 0, wen_tot = 0, ben_tot = 0;
  int hold_err = 0, both_err = 0, idle_err = 0;
  logic prev_stall = 1'b0;
  logic [2*WORD_BITS+1:0] prev_snap = '0;

  always @(negedge CLK) begin
    ncnt++;
    if (!RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ({Weight_valid_out, Bias_valid_out, Weight_out, Bias_out} != prev_snap))
        hold_err++;
      prev_stall = (Weight_valid_out || Bias_valid_out) && !En_in && !layer_done_in;
      prev_snap  = {Weight_valid_out, Bias_valid_out, Weight_out, Bias_out};
      if (Weight_valid_out && En_in) beats.push_back('{1'b0, Weight_out, ncnt});
      if (Bias_valid_out && En_in)   beats.push_back('{1'b1, Bias_out, ncnt});
    end
    if (Weight_valid_out && Bias_valid_out) both_err++;
    if ((!Weight_valid_out && Weight_out != 0) || (!Bias_valid_out && Bias_out != 0)) idle_err++;
    if (Done_out) begin done_tot++; done_last = ncnt; end
    if (Busy_out) busy_tot++;
    if (W_RAM_en_out) wen_tot++;
    if (B_RAM_en_out) ben_tot++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t0, b0, d0, bz0, we0, be0, h0, x0, i0, n;
    beat_t exp_q[$];
    b0 = beats.size(); d0 = done_tot; bz0 = busy_tot; we0 = wen_tot; be0 = ben_tot;
    h0 = hold_err; x0 = both_err; i0 = idle_err;
    Taps_in   = TAP_BITS'(v.taps);
    Num_OC_in = OC_BITS'(v.noc);
    W_base_in = W_ADDR_BITS'(v.wb);
    B_base_in = B_ADDR_BITS'(v.bb);
    En_in = 1'b1;
    Start_in = 1'b1;
    t0 = ncnt + 1;  // the next negedge lies in the cycle Start_in is sampled
    @(posedge CLK); #1;
    Start_in = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      En_in    = !(v.stall_len > 0 && c >= v.stall_at && c < v.stall_at + v.stall_len);
      Start_in = (c == v.restart_at);
      if (c == 1) check({tag, " busy_rise"}, Busy_out, 1);
      @(posedge CLK); #1;
    end
    En_in = 1'b1;
    Start_in = 1'b0;
    for (int oc = 0; oc < v.noc; oc++) begin
      for (int t = 0; t < v.taps; t++)
        exp_q.push_back('{1'b0, wmem[(v.wb + oc*v.taps + t) % (1<<W_ADDR_BITS)], 0});
      exp_q.push_back('{1'b1, bmem[(v.bb + oc) % (1<<B_ADDR_BITS)], 0});
    end
    n = beats.size() - b0;
    check({tag, " beat_count"}, n, v.exp_beats);
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s beat%0d", tag, i),
            {beats[b0+i].bias, beats[b0+i].data}, {exp_q[i].bias, exp_q[i].data});
    if (n > 0 && v.exp_beats > 0) begin
      check({tag, " first_cycle"}, beats[b0].cyc - t0, v.exp_first);
      check({tag, " last_cycle"}, beats[beats.size()-1].cyc - t0, v.exp_last);
    end
    check({tag, " done_count"}, done_tot - d0, 1);
    check({tag, " done_cycle"}, done_last - t0, v.exp_done);
    check({tag, " busy_cycles"}, busy_tot - bz0, v.exp_busy);
    check({tag, " w_reads"}, wen_tot - we0, v.taps * v.noc);
    check({tag, " b_reads"}, ben_tot - be0, v.noc);
    check({tag, " stall_hold"}, hold_err - h0, 0);
    check({tag, " exclusive"}, both_err - x0, 0);
    check({tag, " idle_zero"}, idle_err - i0, 0);
  endtask

  vec_t vecs [7];

  initial begin
    int t0, b0, d0;
    for (int i = 0; i < (1<<W_ADDR_BITS); i++) wmem[i] = WORD_BITS'(32'h1000 + i*7);
    for (int i = 0; i < (1<<B_ADDR_BITS); i++) bmem[i] = WORD_BITS'(32'hB000 + i*13);

    //          taps noc  wb     bb    st_at st_len rst  beats first last done busy
    vecs[0] = '{3,   2,   'h010, 'h04, 0,    0,     0,   8,    2,    9,   11,  10};
    vecs[1] = '{3,   2,   'h010, 'h04, 3,    3,     0,   8,    2,    12,  14,  13};
    vecs[2] = '{0,   3,   'h3FF, 'h3E, 0,    0,     0,   3,    2,    4,   6,   5};
    vecs[3] = '{4,   1,   'h3FE, 'h10, 0,    0,     0,   5,    2,    6,   8,   7};
    vecs[4] = '{3,   2,   'h010, 'h04, 0,    0,     4,   8,    2,    9,   11,  10};
    vecs[5] = '{1,   2,   'h100, 'h20, 0,    0,     0,   4,    2,    5,   7,   6};
    vecs[6] = '{3,   0,   'h010, 'h04, 0,    0,     0,   0,    0,    0,   2,   1};

    // Reset state.
    #12;
    check("rst w_valid", Weight_valid_out, 0);
    check("rst b_valid", Bias_valid_out, 0);
    check("rst w_data", Weight_out, 0);
    check("rst b_data", Bias_out, 0);
    check("rst rams", {W_RAM_en_out, B_RAM_en_out, W_RAM_addr_out, B_RAM_addr_out}, 0);
    check("rst busy_done", {Busy_out, Done_out}, 0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort mid-WEIGHT with a simultaneous Start_in.
    Taps_in = 3; Num_OC_in = 2; W_base_in = 'h010; B_base_in = 'h04;
    En_in = 1'b1; Start_in = 1'b1; d0 = done_tot;
    t0 = ncnt + 1;
    @(posedge CLK); #1; Start_in = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    layer_done_in = 1'b1; Start_in = 1'b1;
    @(posedge CLK); #1;
    layer_done_in = 1'b0; Start_in = 1'b0;
    b0 = beats.size();
    @(negedge CLK);
    check("abort w_valid", Weight_valid_out, 0);
    check("abort b_valid", Bias_valid_out, 0);
    check("abort rams", {W_RAM_en_out, B_RAM_en_out}, 0);
    check("abort busy", Busy_out, 0);
    repeat (6) @(posedge CLK);
    #1;
    check("abort no_beats", beats.size() - b0, 0);
    check("abort no_done", done_tot - d0, 0);
    check("abort cycle", ncnt - t0 >= 4, 1);
    run_vec(vecs[0], "post_abort");

    // Asynchronous reset in the middle of a stream.
    Taps_in = 3; Num_OC_in = 2; W_base_in = 'h010; B_base_in = 'h04;
    En_in = 1'b1; Start_in = 1'b1;
    @(posedge CLK); #1; Start_in = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midrst valids", {Weight_valid_out, Bias_valid_out}, 0);
    check("midrst data", {Weight_out, Bias_out}, 0);
    check("midrst rams", {W_RAM_en_out, B_RAM_en_out, W_RAM_addr_out, B_RAM_addr_out}, 0);
    check("midrst busy_done", {Busy_out, Done_out}, 0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    run_vec(vecs[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
